// File: rtl/bcd_calc_display.sv
// Output end of the keypad calculator: one-digit add/subtract on a rising edge of ready,
// shown signed on a 4-digit multiplexed common-anode 7-segment display.
module bcd_calc_display #(
  parameter int unsigned SCAN_DIV = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] a1,
  input  logic [3:0] op,
  input  logic [3:0] a2,
  input  logic       ready,
  output logic [7:0] seg_out,
  output logic [3:0] dig_out,
  output logic       result_valid,
  output logic       err
);

  localparam int unsigned CW = $clog2(SCAN_DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);
  localparam logic [3:0] OP_ADD = 4'b1010;
  localparam logic [3:0] OP_SUB = 4'b1011;

  typedef enum logic [1:0] {IDLE, CALC, SHOW, ERR} state_t;
  typedef enum logic [1:0] {DISP_IDLE, DISP_SHOW, DISP_ERR} disp_t;

  state_t        state;
  disp_t         disp;
  logic          ready_d;
  logic [3:0]    a1_q, op_q, a2_q;
  logic          res_sign, res_tens;
  logic [3:0]    res_ones;
  logic [CW-1:0] cnt;
  logic [1:0]    idx;

  logic          start;
  logic          illegal;
  logic          is_sub;
  logic [4:0]    diff;
  logic [4:0]    mag;
  logic [4:0]    ones5;
  logic          calc_sign, calc_tens;
  logic          cnt_wrap;
  logic [1:0]    idx_next;
  logic [6:0]    glyph;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  assign start = ready & ~ready_d;

  // Addition reaches 18, which sets bit 4, so the sign is only taken from a subtraction.
  always_comb begin
    illegal   = (a1_q > 4'd9) || (a2_q > 4'd9) || ((op_q != OP_ADD) && (op_q != OP_SUB));
    is_sub    = (op_q == OP_SUB);
    diff      = is_sub ? ({1'b0, a1_q} - {1'b0, a2_q}) : ({1'b0, a1_q} + {1'b0, a2_q});
    calc_sign = is_sub && diff[4];
    mag       = calc_sign ? (~diff + 5'd1) : diff;
    calc_tens = (mag >= 5'd10);
    ones5     = calc_tens ? (mag - 5'd10) : mag;
  end

  always_comb begin
    cnt_wrap = (cnt == CNT_MAX);
    idx_next = cnt_wrap ? idx + 2'd1 : idx;
  end

  // Glyph for the digit that will be selected after this edge, so seg and dig move together.
  always_comb begin
    glyph = '0;
    case (disp)
      DISP_IDLE: if (idx_next == 2'd0) glyph = seg7(4'd0);
      DISP_SHOW: begin
        case (idx_next)
          2'd2:    glyph = res_sign ? 7'h40 : 7'h00;
          2'd1:    glyph = res_tens ? 7'h06 : 7'h00;
          2'd0:    glyph = seg7(res_ones);
          default: glyph = 7'h00;
        endcase
      end
      DISP_ERR: begin
        case (idx_next)
          2'd2:    glyph = 7'h79;
          2'd1:    glyph = 7'h50;
          2'd0:    glyph = 7'h50;
          default: glyph = 7'h00;
        endcase
      end
      default: glyph = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      disp         <= DISP_IDLE;
      ready_d      <= 1'b1;
      a1_q         <= '0;
      op_q         <= '0;
      a2_q         <= '0;
      res_sign     <= 1'b0;
      res_tens     <= 1'b0;
      res_ones     <= '0;
      cnt          <= '0;
      idx          <= '0;
      seg_out      <= '1;
      dig_out      <= '1;
      result_valid <= 1'b0;
      err          <= 1'b0;
    end else begin
      ready_d      <= ready;
      cnt          <= cnt_wrap ? '0 : cnt + 1'b1;
      idx          <= idx_next;
      dig_out      <= ~(4'b0001 << idx_next);
      seg_out      <= {1'b1, ~glyph};
      result_valid <= (disp == DISP_SHOW);
      err          <= (disp == DISP_ERR);
      if (start) begin
        state <= CALC;
        a1_q  <= a1;
        op_q  <= op;
        a2_q  <= a2;
      end else begin
        case (state)
          CALC: begin
            res_sign <= calc_sign;
            res_tens <= calc_tens;
            res_ones <= ones5[3:0];
            if (illegal) begin
              state <= ERR;
              disp  <= DISP_ERR;
            end else begin
              state <= SHOW;
              disp  <= DISP_SHOW;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bcd_calc_display.sv
// Directed self-checking bench for bcd_calc_display with a short scan period.
module tb_bcd_calc_display;

  localparam int unsigned SD = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] a1, op, a2;
  logic       ready;
  logic [7:0] seg_out;
  logic [3:0] dig_out;
  logic       result_valid;
  logic       err;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  always #5 clk = ~clk;

  bcd_calc_display #(.SCAN_DIV(SD)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .a1           (a1),
    .op           (op),
    .a2           (a2),
    .ready        (ready),
    .seg_out      (seg_out),
    .dig_out      (dig_out),
    .result_valid (result_valid),
    .err          (err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  // Align to the first cycle of the digit0 slot, then check every slot's select and segments.
  task automatic check_frame(input string tag, input logic [7:0] e3, input logic [7:0] e2,
                             input logic [7:0] e1, input logic [7:0] e0);
    logic [31:0] pack;
    logic [3:0]  exp_dig;
    int unsigned n;
    pack = {e3, e2, e1, e0};
    n = 0;
    while (dig_out !== 4'b0111 && n < 8 * SD) begin
      tick(1);
      n++;
    end
    n = 0;
    while (dig_out === 4'b0111 && n < 2 * SD) begin
      tick(1);
      n++;
    end
    for (int k = 0; k < 4; k++) begin
      exp_dig = ~(4'b0001 << k);
      check($sformatf("%s_dig%0d", tag, k), 32'(dig_out), 32'(exp_dig));
      check($sformatf("%s_seg%0d", tag, k), 32'(seg_out), 32'(pack[8*k +: 8]));
      tick(SD);
    end
  endtask

  // Raises ready with the given operands; checks flags one and two edges after the start edge.
  task automatic do_op(input string tag, input logic [3:0] x, input logic [3:0] o,
                       input logic [3:0] y, input logic prv, input logic perr,
                       input logic nrv, input logic nerr);
    a1 = x;
    op = o;
    a2 = y;
    ready = 1'b1;
    tick(1);
    tick(1);
    check({tag, "_rv_n1"}, 32'(result_valid), 32'(prv));
    check({tag, "_err_n1"}, 32'(err), 32'(perr));
    tick(1);
    check({tag, "_rv_n2"}, 32'(result_valid), 32'(nrv));
    check({tag, "_err_n2"}, 32'(err), 32'(nerr));
  endtask

  initial begin
    int unsigned n;
    rst_n = 1'b0;
    ready = 1'b0;
    a1 = 4'd0;
    op = 4'd0;
    a2 = 4'd0;
    tick(3);
    check("rst_seg", 32'(seg_out), 32'hFF);
    check("rst_dig", 32'(dig_out), 32'hF);
    check("rst_rv", 32'(result_valid), 32'd0);
    check("rst_err", 32'(err), 32'd0);

    rst_n = 1'b1;
    tick(1);
    check("rel_dig", 32'(dig_out), 32'b1110);
    check("rel_seg", 32'(seg_out), 32'hC0);
    check_frame("idle", 8'hFF, 8'hFF, 8'hFF, 8'hC0);

    do_op("add35", 4'd3, 4'b1010, 4'd5, 1'b0, 1'b0, 1'b1, 1'b0);
    ready = 1'b0;
    check_frame("add35", 8'hFF, 8'hFF, 8'hFF, 8'h80);

    do_op("add99", 4'd9, 4'b1010, 4'd9, 1'b1, 1'b0, 1'b1, 1'b0);
    ready = 1'b0;
    check_frame("add99", 8'hFF, 8'hFF, 8'hF9, 8'h80);

    do_op("sub27", 4'd2, 4'b1011, 4'd7, 1'b1, 1'b0, 1'b1, 1'b0);
    ready = 1'b0;
    check_frame("sub27", 8'hFF, 8'hBF, 8'hFF, 8'h92);

    do_op("badop", 4'd1, 4'b1100, 4'd1, 1'b1, 1'b0, 1'b0, 1'b1);
    ready = 1'b0;
    check_frame("badop", 8'hFF, 8'h86, 8'hAF, 8'hAF);

    do_op("add11", 4'd1, 4'b1010, 4'd1, 1'b0, 1'b1, 1'b1, 1'b0);
    ready = 1'b0;
    check_frame("add11", 8'hFF, 8'hFF, 8'hFF, 8'hA4);

    do_op("hold", 4'd3, 4'b1010, 4'd4, 1'b1, 1'b0, 1'b1, 1'b0);
    a1 = 4'd7;
    tick(50);
    check("hold_rv", 32'(result_valid), 32'd1);
    check_frame("hold", 8'hFF, 8'hFF, 8'hFF, 8'hF8);
    ready = 1'b0;

    n = 0;
    while (dig_out !== 4'b1011 && n < 8 * SD) begin
      tick(1);
      n++;
    end
    check("midrst_idx2", 32'(dig_out), 32'b1011);
    rst_n = 1'b0;
    tick(1);
    check("midrst_seg", 32'(seg_out), 32'hFF);
    check("midrst_dig", 32'(dig_out), 32'hF);
    check("midrst_rv", 32'(result_valid), 32'd0);
    check("midrst_err", 32'(err), 32'd0);
    rst_n = 1'b1;
    tick(1);
    check("midrst_dig0", 32'(dig_out), 32'b1110);
    check("midrst_seg0", 32'(seg_out), 32'hC0);
    check_frame("midrst", 8'hFF, 8'hFF, 8'hFF, 8'hC0);

    rst_n = 1'b0;
    ready = 1'b1;
    a1 = 4'd5;
    op = 4'b1010;
    a2 = 4'd2;
    tick(2);
    rst_n = 1'b1;
    tick(20);
    check("rdyhigh_rv", 32'(result_valid), 32'd0);
    check("rdyhigh_err", 32'(err), 32'd0);
    check_frame("rdyhigh", 8'hFF, 8'hFF, 8'hFF, 8'hC0);
    ready = 1'b0;
    tick(2);

    a1 = 4'd4;
    op = 4'b1010;
    a2 = 4'd4;
    ready = 1'b1;
    tick(1);
    ready = 1'b0;
    tick(2);
    check("b2b_first_rv", 32'(result_valid), 32'd1);
    for (int i = 0; i < 10; i++) begin
      if (i == 2) begin
        a1 = 4'd9;
        op = 4'b1011;
        a2 = 4'd0;
        ready = 1'b1;
      end
      if (i == 3) ready = 1'b0;
      tick(1);
      check($sformatf("b2b_rv%0d", i), 32'(result_valid), 32'd1);
      check($sformatf("b2b_err%0d", i), 32'(err), 32'd0);
    end
    check_frame("b2b", 8'hFF, 8'hFF, 8'hFF, 8'h90);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
